// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the colour-bar test pattern table.
// Latency: n/a. Backpressure: n/a.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int BAR_COUNT = 8;

  // Classic SMPTE-style order, brightest bar on the left.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with reset value; tap exposes the top TAP_W bits one stage early.
// Latency: DEPTH clocks (tap: DEPTH-1). Backpressure: none, free-running.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter int               TAP_W   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [TAP_W-1:0] tap
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_tap_in
      assign tap = din[WIDTH-1 -: TAP_W];
    end else begin : g_tap_stage
      assign tap = stage[DEPTH-2][WIDTH-1 -: TAP_W];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: issues pixel reads and aligns sync/blank/colour to the memory latency.
// Latency: RD_LAT+1 clocks rd_en -> outputs. Backpressure: none. VGA_TESTPAT_EN adds test_en colour bars.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int RD_LAT   = 1,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_TESTPAT_EN
  input  logic        test_en,
`endif
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        rd_en,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ON = (SYNC_POL != 0);

  logic [9:0] h_cnt, v_cnt;
  logic       active, hs_raw, vs_raw, first_px;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign rd_en    = active;
  assign h_addr   = active ? h_cnt : '0;
  assign v_addr   = active ? v_cnt : '0;
  assign hs_raw   = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_ON : ~SYNC_ON;
  assign vs_raw   = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_ON : ~SYNC_ON;
  assign first_px = (h_cnt == '0) && (v_cnt == '0);

  // Colour-control bits sit on top so the early tap carries exactly them.
`ifdef VGA_TESTPAT_EN
  localparam int         FW       = 8;
  localparam logic [7:0] FLAG_RST = {4'b0000, ~SYNC_ON, ~SYNC_ON, 1'b0};
  localparam logic [12:0] H_ACT13 = 13'(H_ACTIVE);
  logic [2:0] bar_idx;
  assign bar_idx = 3'({h_addr, 3'b000} / H_ACT13);
  logic [FW-1:0] flags_in;
  assign flags_in = {test_en, bar_idx, active, hs_raw, vs_raw, first_px};
`else
  localparam int         FW       = 4;
  localparam logic [3:0] FLAG_RST = {1'b0, ~SYNC_ON, ~SYNC_ON, 1'b0};
  logic [FW-1:0] flags_in;
  assign flags_in = {active, hs_raw, vs_raw, first_px};
`endif

  logic [FW-1:0] flags_q;
  logic [FW-4:0] ctl_tap;

  vga_delay_line #(
    .WIDTH   (FW),
    .DEPTH   (RD_LAT + 1),
    .TAP_W   (FW - 3),
    .RST_VAL (FLAG_RST)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (flags_in),
    .dout (flags_q),
    .tap  (ctl_tap)
  );

  assign valid       = flags_q[3];
  assign hsync       = flags_q[2];
  assign vsync       = flags_q[1];
  assign frame_start = flags_q[0];

  logic [23:0] pix_src, pix_q;

`ifdef VGA_TESTPAT_EN
  assign pix_src = ctl_tap[4] ? bar_color(ctl_tap[3:1]) : vga_data;
`else
  assign pix_src = vga_data;
`endif

  // ctl_tap[0] is active delayed RD_LAT clocks, i.e. aligned with the returning vga_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pix_q <= '0;
    else if (ctl_tap[0]) pix_q <= pix_src;
    else                 pix_q <= '0;
  end

  assign {vga_r, vga_g, vga_b} = pix_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: three latency variants on a 14x7 raster against a position-from-time model.
module tb_vga_scan_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

`ifdef VGA_TESTPAT_EN
  localparam bit HAS_TP = 1'b1;
`else
  localparam bit HAS_TP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          te_drive;
  logic [15:0] key;
  int          t;
  int          checks = 0;
  int          errors = 0;
  bit          te_hist [1024];
  int          vs_low [4];

  logic [9:0]  h0, v0, h1, v1, h2, v2;
  logic        rd0, rd1, rd2, val0, val1, val2;
  logic        hs0, hs1, hs2, vs0, vs1, vs2, fs0, fs1, fs2;
  logic [7:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic [15:0] fc0, fc1, fc2;
  logic [23:0] vd0, vd1, vd2, m1, m2a, m2b, noise;

  always #5 clk = ~clk;

  vga_scan_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                 .V_SYNC(VSW), .V_BP(VB), .RD_LAT(0), .SYNC_POL(0)) u_lat0 (
    .clk(clk), .rst(rst),
`ifdef VGA_TESTPAT_EN
    .test_en(te_drive),
`endif
    .vga_data(vd0), .h_addr(h0), .v_addr(v0), .rd_en(rd0), .hsync(hs0), .vsync(vs0),
    .valid(val0), .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0), .frame_cnt(fc0));

  vga_scan_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                 .V_SYNC(VSW), .V_BP(VB), .RD_LAT(1), .SYNC_POL(0)) u_lat1 (
    .clk(clk), .rst(rst),
`ifdef VGA_TESTPAT_EN
    .test_en(te_drive),
`endif
    .vga_data(vd1), .h_addr(h1), .v_addr(v1), .rd_en(rd1), .hsync(hs1), .vsync(vs1),
    .valid(val1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1), .frame_cnt(fc1));

  vga_scan_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                 .V_SYNC(VSW), .V_BP(VB), .RD_LAT(2), .SYNC_POL(0)) u_lat2 (
    .clk(clk), .rst(rst),
`ifdef VGA_TESTPAT_EN
    .test_en(te_drive),
`endif
    .vga_data(vd2), .h_addr(h2), .v_addr(v2), .rd_en(rd2), .hsync(hs2), .vsync(vs2),
    .valid(val2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_start(fs2), .frame_cnt(fc2));

  // Pixel memory: content is {key, x*16+y}; idle reads return noise.
  function automatic logic [23:0] pix(input logic [15:0] k, input logic [9:0] h, input logic [9:0] v);
    return {k, 8'(h * 16 + v)};
  endfunction

  always @(posedge clk) begin
    noise <= 24'($urandom);
    m1    <= rd1 ? pix(key, h1, v1) : 24'($urandom);
    m2a   <= rd2 ? pix(key, h2, v2) : 24'($urandom);
    m2b   <= m2a;
  end
  always_comb vd0 = rd0 ? pix(key, h0, v0) : noise;
  assign vd1 = m1;
  assign vd2 = m2b;

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Raster position is a pure function of clocks since reset release; outputs show position t-lat-1.
  task automatic check_dut(input int lat, input logic rd, input logic [9:0] ha, input logic [9:0] va,
                           input logic vld, input logic hs, input logic vs, input logic fs,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [15:0] fc);
    int p, h, v, td;
    bit a, ea, ehs, evs, efs;
    logic [23:0] col;
    p = t % FT; h = p % HT; v = p / HT;
    a = (h < HA) && (v < VA);
    chk($sformatf("L%0d rd_en t=%0d", lat, t), 32'(rd), 32'(a));
    chk($sformatf("L%0d h_addr t=%0d", lat, t), 32'(ha), a ? h : 0);
    chk($sformatf("L%0d v_addr t=%0d", lat, t), 32'(va), a ? v : 0);
    ea = 0; ehs = 1; evs = 1; efs = 0; col = '0;
    if (t >= lat + 1) begin
      td = t - lat - 1;
      p = td % FT; h = p % HT; v = p / HT;
      ea  = (h < HA) && (v < VA);
      ehs = !(h >= HA + HF && h < HA + HF + HSW);
      evs = !(v >= VA + VF && v < VA + VF + VSW);
      efs = (p == 0);
      if (ea) col = te_hist[td % 1024] ? bar_rgb(h * 8 / HA) : {key, 8'(h * 16 + v)};
    end
    chk($sformatf("L%0d valid t=%0d", lat, t), 32'(vld), 32'(ea));
    chk($sformatf("L%0d hsync t=%0d", lat, t), 32'(hs), 32'(ehs));
    chk($sformatf("L%0d vsync t=%0d", lat, t), 32'(vs), 32'(evs));
    chk($sformatf("L%0d frame_start t=%0d", lat, t), 32'(fs), 32'(efs));
    chk($sformatf("L%0d rgb t=%0d", lat, t), 32'({r, g, b}), 32'(col));
    chk($sformatf("L%0d frame_cnt t=%0d", lat, t), 32'(fc), 32'(16'(t / FT)));
  endtask

  task automatic check_all();
    check_dut(0, rd0, h0, v0, val0, hs0, vs0, fs0, r0, g0, b0, fc0);
    check_dut(1, rd1, h1, v1, val1, hs1, vs1, fs1, r1, g1, b1, fc1);
    check_dut(2, rd2, h2, v2, val2, hs2, vs2, fs2, r2, g2, b2, fc2);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (!rst) t++;
    @(negedge clk);
    check_all();
    if (HAS_TP && $urandom_range(0, 3) == 0) te_drive = ~te_drive;
    te_hist[t % 1024] = te_drive;
  endtask

  // Asynchronous reset landing just after an edge, checked before the next edge.
  task automatic async_reset(input int hold);
    @(posedge clk);
    if (!rst) t++;
    #1;
    rst = 1'b1;
    t   = 0;
    key = 16'($urandom);
    #1;
    check_all();
    repeat (hold) run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    t = 0;
    te_drive = 1'b0;
    key = 16'($urandom);
    for (int i = 0; i < 4; i++) vs_low[i] = 0;

    repeat (3) run_cycle();
    rst = 1'b0;

    // Reset in the middle of frame 0 at (x=5, y=2).
    while (t < 2 * HT + 4) run_cycle();
    @(posedge clk);
    t++;
    #1;
    chk("pre-reset h_addr", 32'(h1), 32'd5);
    chk("pre-reset v_addr", 32'(v1), 32'd2);
    rst = 1'b1;
    t   = 0;
    key = 16'($urandom);
    #1;
    check_all();
    chk("mid-frame reset frame_cnt", 32'(fc1), 32'd0);
    repeat (2) run_cycle();
    rst = 1'b0;

    // Three full frames.
    for (int i = 0; i < 3 * FT; i++) begin
      run_cycle();
      if (!vs1) vs_low[t / FT]++;
    end
    chk("frame_cnt after 3 frames L0", 32'(fc0), 32'd3);
    chk("frame_cnt after 3 frames L1", 32'(fc1), 32'd3);
    chk("frame_cnt after 3 frames L2", 32'(fc2), 32'd3);
    for (int f = 0; f < 3; f++) chk($sformatf("vsync low clocks frame %0d", f), 32'(vs_low[f]), 32'd14);
    chk("vsync low clocks after frame 3", 32'(vs_low[3]), 32'd0);

    for (int k = 0; k < 3; k++) begin
      async_reset($urandom_range(1, 3));
      repeat ($urandom_range(20, 300)) run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
